// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scanner_pkg
// Shared definitions for the 4x4 keypad scanner and its consumer (the
// calculator state machine): 5-bit key codes, scanner state encodings and
// a few idle/reset constants.
// -----------------------------------------------------------------------------
package keypad_scanner_pkg;

    // Key codes: hex digits map directly, KEY_NONE sits just above them.
    localparam logic [4:0] KEY_0    = 5'h00;
    localparam logic [4:0] KEY_1    = 5'h01;
    localparam logic [4:0] KEY_2    = 5'h02;
    localparam logic [4:0] KEY_3    = 5'h03;
    localparam logic [4:0] KEY_4    = 5'h04;
    localparam logic [4:0] KEY_5    = 5'h05;
    localparam logic [4:0] KEY_6    = 5'h06;
    localparam logic [4:0] KEY_7    = 5'h07;
    localparam logic [4:0] KEY_8    = 5'h08;
    localparam logic [4:0] KEY_9    = 5'h09;
    localparam logic [4:0] KEY_A    = 5'h0A;
    localparam logic [4:0] KEY_B    = 5'h0B;
    localparam logic [4:0] KEY_C    = 5'h0C;
    localparam logic [4:0] KEY_D    = 5'h0D;
    localparam logic [4:0] KEY_E    = 5'h0E;
    localparam logic [4:0] KEY_F    = 5'h0F;
    localparam logic [4:0] KEY_NONE = 5'h10;

    // Scanner state encodings.
    typedef enum logic [1:0] {
        SK_SCAN  = 2'd0,
        SK_DEB   = 2'd1,
        SK_PRESS = 2'd2,
        SK_REL   = 2'd3
    } scan_state_t;

    // All rows released (pulled up) and the first column drive pattern.
    localparam logic [3:0] ROWS_IDLE = 4'hF;
    localparam logic [3:0] COL_FIRST = 4'b1110;

endpackage

// File: rtl/keypad_sync.sv
// -----------------------------------------------------------------------------
// keypad_sync
// Two-flop synchronizer for the four asynchronous, active-low keypad rows.
// Resets to all-ones so the scanner sees "no key" straight out of reset.
//
// Ports
//   clk   in   1  system clock
//   rst   in   1  synchronous, active-high reset
//   din   in   4  raw row_n from the pads
//   dout  out  4  synchronized rows
// -----------------------------------------------------------------------------
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    output logic [3:0] dout
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 4'hF;
            dout <= 4'hF;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 hex matrix keypad, debounces press and release, and presents a
// 5-bit key code. key holds the pressed code while the key is down and goes
// back to KEY_NONE only after a debounced release; key_strobe pulses once on
// the cycle a new code first appears.
//
// Key map (row r / column c, c0 = col_n[0]):
//   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
//
// Parameters
//   SCAN_DIV      clk cycles per column dwell (>=4), rows sampled on the last
//   DEBOUNCE_CYC  stable cycles needed to accept a press or release (>=2)
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   row_n       in   4  keypad rows, active-low, asynchronous
//   col_n       out  4  column drive, active-low one-hot
//   key         out  5  current key code or KEY_NONE
//   key_strobe  out  1  one-cycle pulse when a new code is presented
//
// state    | meaning
// SK_SCAN  | rotating columns, sampling rows at the end of each dwell
// SK_DEB   | single row seen; column frozen, waiting for a stable press
// SK_PRESS | key accepted and held; waiting for all rows to go high
// SK_REL   | rows high; waiting for a stable release
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [4:0] key,
    output logic       key_strobe
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYC);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);

    logic [3:0]        rs;
    scan_state_t       state;
    logic [SCAN_W-1:0] scan_cnt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [3:0]        pattern;
    logic [1:0]        col_idx;

    logic              single_low;
    logic [1:0]        row_idx;
    logic [4:0]        key_code;

    keypad_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (row_n),
        .dout (rs)
    );

    // Only a single low row is a valid press; two or more rows in the same
    // column are ambiguous and left for the next scan pass.
    always_comb begin
        single_low = 1'b0;
        case (rs)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    end

    always_comb begin
        row_idx = 2'd0;
        case (pattern)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_comb begin
        key_code = KEY_NONE;
        case ({col_idx, row_idx})
            4'h0: key_code = KEY_1;
            4'h1: key_code = KEY_4;
            4'h2: key_code = KEY_7;
            4'h3: key_code = KEY_E;
            4'h4: key_code = KEY_2;
            4'h5: key_code = KEY_5;
            4'h6: key_code = KEY_8;
            4'h7: key_code = KEY_0;
            4'h8: key_code = KEY_3;
            4'h9: key_code = KEY_6;
            4'hA: key_code = KEY_9;
            4'hB: key_code = KEY_F;
            4'hC: key_code = KEY_A;
            4'hD: key_code = KEY_B;
            4'hE: key_code = KEY_C;
            4'hF: key_code = KEY_D;
            default: key_code = KEY_NONE;
        endcase
    end

    // Counters leave their state on reaching the terminal value, so they
    // never wrap while a state is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SK_SCAN;
            col_n      <= COL_FIRST;
            col_idx    <= 2'd0;
            scan_cnt   <= '0;
            deb_cnt    <= '0;
            pattern    <= ROWS_IDLE;
            key        <= KEY_NONE;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            case (state)
                SK_SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (single_low) begin
                            pattern <= rs;
                            deb_cnt <= '0;
                            state   <= SK_DEB;
                        end else begin
                            col_n   <= {col_n[2:0], col_n[3]};
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SCAN_W'(1);
                    end
                end

                SK_DEB: begin
                    if (rs == pattern) begin
                        if (deb_cnt == DEB_LAST) begin
                            key        <= key_code;
                            key_strobe <= 1'b1;
                            state      <= SK_PRESS;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        scan_cnt <= '0;
                        col_n    <= {col_n[2:0], col_n[3]};
                        col_idx  <= col_idx + 2'd1;
                        state    <= SK_SCAN;
                    end
                end

                // Anything other than all-high (including a second key in
                // this column) keeps the current key held.
                SK_PRESS: begin
                    if (rs == ROWS_IDLE) begin
                        deb_cnt <= '0;
                        state   <= SK_REL;
                    end
                end

                SK_REL: begin
                    if (rs == ROWS_IDLE) begin
                        if (deb_cnt == DEB_LAST) begin
                            key      <= KEY_NONE;
                            scan_cnt <= '0;
                            col_n    <= {col_n[2:0], col_n[3]};
                            col_idx  <= col_idx + 2'd1;
                            state    <= SK_SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        // Release glitch: key was never dropped, so no strobe.
                        state <= SK_PRESS;
                    end
                end

                default: state <= SK_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CYC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [4:0] key;
    logic       key_strobe;

    // pressed[r*4+c] = key at row r, column c is physically down
    logic [15:0] pressed;

    int n_checks   = 0;
    int n_fail     = 0;
    int strobe_cnt = 0;
    int dbl_strobe = 0;
    logic armed    = 1'b1;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_n      (row_n),
        .col_n      (col_n),
        .key        (key),
        .key_strobe (key_strobe)
    );

    // Keypad matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // Strobe counter and "no second strobe without passing through KEY_NONE" monitor.
    always @(posedge clk) begin
        if (key_strobe) begin
            strobe_cnt <= strobe_cnt + 1;
            if (!armed) dbl_strobe <= dbl_strobe + 1;
            armed <= 1'b0;
        end else if (key == 5'h10) begin
            armed <= 1'b1;
        end
    end

    typedef struct {
        int         r;
        int         c;
        logic [4:0] code;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic wait_strobe(input int bound, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < bound && !ok) begin
            @(negedge clk);
            cyc++;
            if (key_strobe) ok = 1'b1;
        end
    endtask

    task automatic wait_none(input int bound, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < bound && !ok) begin
            @(negedge clk);
            cyc++;
            if (key == 5'h10) ok = 1'b1;
        end
    endtask

    initial begin
        logic [3:0] rot[4];
        int  cyc;
        bit  ok;
        int  base;

        rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;

        vecs[0]  = '{0, 0, 5'h01}; vecs[1]  = '{0, 1, 5'h02};
        vecs[2]  = '{0, 2, 5'h03}; vecs[3]  = '{0, 3, 5'h0A};
        vecs[4]  = '{1, 0, 5'h04}; vecs[5]  = '{1, 1, 5'h05};
        vecs[6]  = '{1, 2, 5'h06}; vecs[7]  = '{1, 3, 5'h0B};
        vecs[8]  = '{2, 0, 5'h07}; vecs[9]  = '{2, 1, 5'h08};
        vecs[10] = '{2, 2, 5'h09}; vecs[11] = '{2, 3, 5'h0C};
        vecs[12] = '{3, 0, 5'h0E}; vecs[13] = '{3, 1, 5'h00};
        vecs[14] = '{3, 2, 5'h0F}; vecs[15] = '{3, 3, 5'h0D};

        // 1. Reset state and idle column rotation
        rst     = 1'b1;
        pressed = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_col_n", int'(col_n), 'hE);
        check("reset_key", int'(key), 'h10);
        check("reset_strobe", int'(key_strobe), 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("idle_col_n", int'(col_n), int'(rot[((i + 1) / 4) % 4]));
        end
        check("idle_strobes", strobe_cnt, 0);
        check("idle_key", int'(key), 'h10);

        // Every key once via the table
        for (int v = 0; v < 16; v++) begin
            base = strobe_cnt;
            pressed[vecs[v].r*4 + vecs[v].c] = 1'b1;
            wait_strobe(300, cyc, ok);
            check("tbl_strobe_seen", int'(ok), 1);
            check("tbl_key_code", int'(key), int'(vecs[v].code));
            repeat (5) @(negedge clk);
            check("tbl_key_hold", int'(key), int'(vecs[v].code));
            pressed[vecs[v].r*4 + vecs[v].c] = 1'b0;
            wait_none(100, cyc, ok);
            check("tbl_release_seen", int'(ok), 1);
            repeat (2) @(negedge clk);
            check("tbl_strobe_count", strobe_cnt - base, 1);
        end

        // 2. Hold '6' for 40 clk, release timing
        base = strobe_cnt;
        pressed[1*4+2] = 1'b1;
        wait_strobe(300, cyc, ok);
        check("six_strobe_seen", int'(ok), 1);
        check("six_key", int'(key), 'h06);
        repeat (35) @(negedge clk);
        check("six_hold", int'(key), 'h06);
        pressed[1*4+2] = 1'b0;
        wait_none(50, cyc, ok);
        check("six_release_seen", int'(ok), 1);
        check("six_release_cycles", cyc, 3 + DEBOUNCE_CYC);
        repeat (2) @(negedge clk);
        check("six_strobe_count", strobe_cnt - base, 1);

        // 3. Bouncing '0'
        base = strobe_cnt;
        for (int i = 0; i < 7; i++) begin
            pressed[3*4+1] = (i % 2 == 0);
            repeat (3) @(negedge clk);
        end
        check("bounce_no_strobe", strobe_cnt - base, 0);
        wait_strobe(300, cyc, ok);
        check("bounce_strobe_seen", int'(ok), 1);
        check("bounce_key", int'(key), 'h00);
        check("bounce_settle", int'(cyc + 3 >= DEBOUNCE_CYC + 2), 1);
        pressed[3*4+1] = 1'b0;
        wait_none(100, cyc, ok);
        check("bounce_release_seen", int'(ok), 1);
        repeat (2) @(negedge clk);
        check("bounce_strobe_count", strobe_cnt - base, 1);

        // 4. Release glitch on 'A'
        base = strobe_cnt;
        pressed[0*4+3] = 1'b1;
        wait_strobe(300, cyc, ok);
        check("glitch_strobe_seen", int'(ok), 1);
        check("glitch_key", int'(key), 'h0A);
        pressed[0*4+3] = 1'b0;
        repeat (4) @(negedge clk);
        pressed[0*4+3] = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_key_held", int'(key), 'h0A);
        check("glitch_one_strobe", strobe_cnt - base, 1);
        pressed[0*4+3] = 1'b0;
        wait_none(100, cyc, ok);
        check("glitch_release_seen", int'(ok), 1);

        // 5. Two rows in one column ('2' and '5')
        base = strobe_cnt;
        pressed[0*4+1] = 1'b1;
        pressed[1*4+1] = 1'b1;
        repeat (60) @(negedge clk);
        check("multirow_no_strobe", strobe_cnt - base, 0);
        check("multirow_key", int'(key), 'h10);
        pressed[1*4+1] = 1'b0;
        wait_strobe(300, cyc, ok);
        check("multirow_strobe_seen", int'(ok), 1);
        check("multirow_key_two", int'(key), 'h02);
        pressed[0*4+1] = 1'b0;
        wait_none(100, cyc, ok);
        check("multirow_release_seen", int'(ok), 1);

        // 6. Reset while 'F' is held
        pressed[3*4+2] = 1'b1;
        wait_strobe(300, cyc, ok);
        check("rst_strobe_seen", int'(ok), 1);
        check("rst_key_before", int'(key), 'h0F);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_key_after", int'(key), 'h10);
        check("rst_col_after", int'(col_n), 'hE);
        check("rst_strobe_after", int'(key_strobe), 0);
        rst  = 1'b0;
        base = strobe_cnt;
        wait_strobe(300, cyc, ok);
        check("rst_restrobe_seen", int'(ok), 1);
        check("rst_restrobe_key", int'(key), 'h0F);
        pressed[3*4+2] = 1'b0;
        wait_none(100, cyc, ok);
        check("rst_release_seen", int'(ok), 1);
        repeat (2) @(negedge clk);
        check("rst_restrobe_count", strobe_cnt - base, 1);

        check("double_strobe", dbl_strobe, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
